// File: rtl/router_output_channel.sv
// Output channel stage of one ring-router port: even/odd VC packet buffers.
// The write VC takes the arbitration winner; the opposite VC drives the link.
module router_output_channel #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned HOP_LSB   = 48,
  parameter int unsigned HOP_W     = 8,
  parameter bit          HOP_SHIFT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              win0,
  input  logic              win1,
  input  logic [DATA_W-1:0] in0_data,
  input  logic [DATA_W-1:0] in1_data,
  output logic              wr_empty,
  output logic              empty_even,
  output logic              empty_odd,
  input  logic              ri,
  output logic              so,
  output logic [DATA_W-1:0] do_data,
  output logic              err
);

  logic              full_even_q, full_even_d;
  logic              full_odd_q, full_odd_d;
  logic [DATA_W-1:0] buf_even_q, buf_even_d;
  logic [DATA_W-1:0] buf_odd_q, buf_odd_d;
  logic              err_q, err_d;

  logic              win_any;
  logic              wr_full;
  logic              wr_en;
  logic              send_full;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    win_any   = win0 | win1;
    // polarity=0 writes even / sends odd; polarity=1 the reverse
    wr_full   = polarity ? full_odd_q : full_even_q;
    send_full = polarity ? full_even_q : full_odd_q;
    wr_en     = win_any & ~wr_full;

    sel_data = win0 ? in0_data : in1_data;
    wr_data  = sel_data;
    if (HOP_SHIFT) begin
      wr_data[HOP_LSB +: HOP_W] = sel_data[HOP_LSB +: HOP_W] >> 1;
    end

    so      = send_full & ri;
    do_data = '0;
    if (so) begin
      do_data = polarity ? buf_even_q : buf_odd_q;
    end

    wr_empty   = ~wr_full;
    empty_even = ~full_even_q;
    empty_odd  = ~full_odd_q;
    err        = err_q;
  end

  always_comb begin
    full_even_d = full_even_q;
    full_odd_d  = full_odd_q;
    buf_even_d  = buf_even_q;
    buf_odd_d   = buf_odd_q;
    err_d       = err_q | (win0 & win1) | (win_any & wr_full);

    if (polarity) begin
      if (wr_en) begin
        full_odd_d = 1'b1;
        buf_odd_d  = wr_data;
      end
      if (so) begin
        full_even_d = 1'b0;
      end
    end else begin
      if (wr_en) begin
        full_even_d = 1'b1;
        buf_even_d  = wr_data;
      end
      if (so) begin
        full_odd_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_even_q <= 1'b0;
      full_odd_q  <= 1'b0;
      buf_even_q  <= '0;
      buf_odd_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      full_even_q <= full_even_d;
      full_odd_q  <= full_odd_d;
      buf_even_q  <= buf_even_d;
      buf_odd_q   <= buf_odd_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_router_output_channel.sv
// Bench for router_output_channel: directed vector table, random traffic against
// a VC-slot reference model, and a full-rate stream on a pass-through instance.
module tb_router_output_channel;

  logic        clk;
  logic        reset;
  logic        polarity;
  logic        win0, win1;
  logic [63:0] in0_data, in1_data;
  logic        ri;

  logic        wr_empty, empty_even, empty_odd, so, err;
  logic [63:0] do_data;
  logic        pe_wr_empty, pe_empty_even, pe_empty_odd, pe_so, pe_err;
  logic [63:0] pe_do_data;

  int n_vec;
  int n_bad;

  // Reference model: per-VC slot (index 0 = even, 1 = odd)
  bit          m_full[2];
  logic [63:0] m_data_sh[2];
  logic [63:0] m_data_pe[2];
  bit          m_err;

  logic        smp_so, smp_pe_so;
  logic [63:0] smp_do, smp_pe_do;
  logic        smp_err, smp_ee, smp_eo, smp_wre;

  typedef struct {
    logic        rst, pol, w0, w1;
    logic [63:0] i0, i1;
    logic        r;
    logic        e_so;
    logic [63:0] e_do;
    logic        e_err, e_ee, e_eo, e_wre;
  } vec_t;

  vec_t tbl[24];

  router_output_channel #(
    .DATA_W(64), .HOP_LSB(48), .HOP_W(8), .HOP_SHIFT(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .polarity(polarity), .win0(win0), .win1(win1),
    .in0_data(in0_data), .in1_data(in1_data), .wr_empty(wr_empty),
    .empty_even(empty_even), .empty_odd(empty_odd), .ri(ri), .so(so),
    .do_data(do_data), .err(err)
  );

  router_output_channel #(
    .DATA_W(64), .HOP_LSB(48), .HOP_W(8), .HOP_SHIFT(1'b0)
  ) dut_pe (
    .clk(clk), .reset(reset), .polarity(polarity), .win0(win0), .win1(win1),
    .in0_data(in0_data), .in1_data(in1_data), .wr_empty(pe_wr_empty),
    .empty_even(pe_empty_even), .empty_odd(pe_empty_odd), .ri(ri), .so(pe_so),
    .do_data(pe_do_data), .err(pe_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] hop_shift(input logic [63:0] d);
    logic [63:0] hop;
    hop = (d >> 48) & 64'hFF;
    return (d & ~(64'hFF << 48)) | ((hop / 2) << 48);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle, check outputs against the model before the edge, then advance the model.
  task automatic apply(input logic rst, input logic pol, input logic w0, input logic w1,
                       input logic [63:0] i0, input logic [63:0] i1, input logic r);
    bit          e_so;
    logic [63:0] d;
    int          wv, sv;
    @(negedge clk);
    reset = rst; polarity = pol; win0 = w0; win1 = w1;
    in0_data = i0; in1_data = i1; ri = r;
    #1;
    wv = pol ? 1 : 0;
    sv = 1 - wv;
    e_so = m_full[sv] && r;
    smp_so = so; smp_do = do_data; smp_pe_so = pe_so; smp_pe_do = pe_do_data;
    smp_err = err; smp_ee = empty_even; smp_eo = empty_odd; smp_wre = wr_empty;
    check("so", {63'd0, so}, {63'd0, e_so});
    check("do_data", do_data, e_so ? m_data_sh[sv] : 64'd0);
    check("pe_so", {63'd0, pe_so}, {63'd0, e_so});
    check("pe_do_data", pe_do_data, e_so ? m_data_pe[sv] : 64'd0);
    check("err", {63'd0, err}, {63'd0, m_err});
    check("pe_err", {63'd0, pe_err}, {63'd0, m_err});
    check("empty_even", {63'd0, empty_even}, {63'd0, !m_full[0]});
    check("empty_odd", {63'd0, empty_odd}, {63'd0, !m_full[1]});
    check("wr_empty", {63'd0, wr_empty}, {63'd0, !m_full[wv]});
    @(posedge clk);
    if (rst) begin
      m_full = '{0, 0};
      m_data_sh = '{64'd0, 64'd0};
      m_data_pe = '{64'd0, 64'd0};
      m_err = 0;
    end else begin
      if (w0 || w1) begin
        if (w0 && w1) m_err = 1;
        if (m_full[wv]) begin
          m_err = 1;
        end else begin
          d = w0 ? i0 : i1;
          m_full[wv] = 1;
          m_data_sh[wv] = hop_shift(d);
          m_data_pe[wv] = d;
        end
      end
      if (e_so) m_full[sv] = 0;
    end
  endtask

  localparam logic [63:0] PA  = 64'h00F0_0000_0000_00AA;
  localparam logic [63:0] PAS = 64'h0078_0000_0000_00AA;
  localparam logic [63:0] PB  = 64'h0004_0000_0000_0011;
  localparam logic [63:0] PBS = 64'h0002_0000_0000_0011;

  logic [63:0] pkts[20];
  logic [63:0] exp_q[$];
  logic [63:0] exp_pkt;
  int          sends;
  bit          pol_r;

  initial begin
    n_vec = 0; n_bad = 0;
    reset = 1'b1; polarity = 1'b0; win0 = 1'b0; win1 = 1'b0;
    in0_data = '0; in1_data = '0; ri = 1'b0;
    repeat (2) @(posedge clk);
    m_full = '{0, 0};
    m_data_sh = '{64'd0, 64'd0};
    m_data_pe = '{64'd0, 64'd0};
    m_err = 0;

    // idle after reset, polarity toggling
    for (int i = 0; i < 10; i++) apply(1'b0, i[0], 1'b0, 1'b0, 64'd0, 64'd0, 1'b1);

    //         rst pol w0 w1 i0      i1     ri  so  do    err ee eo wre
    tbl[0]  = '{0, 0, 1, 0, PA,     64'd0, 0,  0, 64'd0, 0, 1, 1, 1};
    tbl[1]  = '{0, 1, 0, 0, 64'd0,  64'd0, 1,  1, PAS,   0, 0, 1, 1};
    tbl[2]  = '{0, 0, 0, 0, 64'd0,  64'd0, 0,  0, 64'd0, 0, 1, 1, 1};
    tbl[3]  = '{0, 1, 1, 0, PB,     64'd0, 0,  0, 64'd0, 0, 1, 1, 1};
    tbl[4]  = '{0, 0, 0, 0, 64'd0,  64'd0, 0,  0, 64'd0, 0, 1, 0, 1};
    tbl[5]  = '{0, 1, 0, 0, 64'd0,  64'd0, 0,  0, 64'd0, 0, 1, 0, 0};
    tbl[6]  = tbl[4];
    tbl[7]  = tbl[5];
    tbl[8]  = tbl[4];
    tbl[9]  = tbl[5];
    tbl[10] = '{0, 0, 0, 0, 64'd0,  64'd0, 1,  1, PBS,   0, 1, 0, 1};
    tbl[11] = '{0, 1, 0, 0, 64'd0,  64'd0, 1,  0, 64'd0, 0, 1, 1, 1};
    tbl[12] = '{0, 0, 1, 0, 64'd1,  64'd0, 0,  0, 64'd0, 0, 1, 1, 1};
    tbl[13] = '{0, 1, 0, 0, 64'd0,  64'd0, 0,  0, 64'd0, 0, 0, 1, 1};
    tbl[14] = '{0, 0, 0, 1, 64'd0,  64'd2, 0,  0, 64'd0, 0, 0, 1, 0};
    tbl[15] = '{0, 1, 0, 0, 64'd0,  64'd0, 1,  1, 64'd1, 1, 0, 1, 1};
    tbl[16] = '{0, 0, 0, 0, 64'd0,  64'd0, 1,  0, 64'd0, 1, 1, 1, 1};
    tbl[17] = '{0, 1, 1, 0, 64'd7,  64'd0, 0,  0, 64'd0, 1, 1, 1, 1};
    tbl[18] = '{0, 0, 1, 0, 64'd8,  64'd0, 0,  0, 64'd0, 1, 1, 0, 1};
    tbl[19] = '{1, 1, 1, 0, 64'd9,  64'd0, 1,  1, 64'd8, 1, 0, 0, 0};
    tbl[20] = '{0, 0, 1, 1, 64'd5,  64'd6, 1,  0, 64'd0, 0, 1, 1, 1};
    tbl[21] = '{0, 1, 0, 0, 64'd0,  64'd0, 1,  1, 64'd5, 1, 0, 1, 1};
    tbl[22] = '{1, 0, 0, 0, 64'd0,  64'd0, 0,  0, 64'd0, 1, 1, 1, 1};
    tbl[23] = '{0, 1, 0, 0, 64'd0,  64'd0, 0,  0, 64'd0, 0, 1, 1, 1};

    for (int i = 0; i < 24; i++) begin
      apply(tbl[i].rst, tbl[i].pol, tbl[i].w0, tbl[i].w1, tbl[i].i0, tbl[i].i1, tbl[i].r);
      check($sformatf("tbl%0d.so", i), {63'd0, smp_so}, {63'd0, tbl[i].e_so});
      check($sformatf("tbl%0d.do", i), smp_do, tbl[i].e_do);
      check($sformatf("tbl%0d.err", i), {63'd0, smp_err}, {63'd0, tbl[i].e_err});
      check($sformatf("tbl%0d.ee", i), {63'd0, smp_ee}, {63'd0, tbl[i].e_ee});
      check($sformatf("tbl%0d.eo", i), {63'd0, smp_eo}, {63'd0, tbl[i].e_eo});
      check($sformatf("tbl%0d.wre", i), {63'd0, smp_wre}, {63'd0, tbl[i].e_wre});
    end

    // random traffic, occasional reset
    pol_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      apply($urandom_range(0, 199) == 0, pol_r, r < 35, r >= 25 && r < 60,
            {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 2) != 0);
      pol_r = ~pol_r;
    end

    // full-rate streaming on the pass-through instance
    apply(1'b1, pol_r, 1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
    pol_r = ~pol_r;
    for (int i = 0; i < 20; i++) pkts[i] = {$urandom, 24'd0, i[7:0]} ^ {32'd0, $urandom};
    sends = 0;
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) begin
        apply(1'b0, pol_r, !i[0], i[0], pkts[i], pkts[i], 1'b1);
      end else begin
        apply(1'b0, pol_r, 1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
      end
      pol_r = ~pol_r;
      if (i > 0) begin
        check($sformatf("stream%0d.so", i), {63'd0, smp_pe_so}, 64'd1);
      end
      if (smp_pe_so) begin
        sends++;
        exp_pkt = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
        check($sformatf("stream%0d.data", i), smp_pe_do, exp_pkt);
      end
      if (i < 20) exp_q.push_back(pkts[i]);
    end
    check("stream.sends", 64'(sends), 64'd20);
    check("stream.err", {63'd0, pe_err}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/router_output_channel.md
# router_output_channel

Output-side channel stage of one ring-router port (CW, CCW or PE), directly downstream of that port's 2-input round-robin arbitrator. It holds one even and one odd virtual-channel (VC) packet buffer, latches the arbitration winner's packet into the VC active for the current polarity, and drives the link handshake toward the next router or PE from the opposite VC. It also reports per-VC emptiness back to the arbitrator (its `output_empty` input).

## Interface
Parameters:
- DATA_W, 64, packet width in bits.
- HOP_LSB, 48, LSB of the hop-count field in the packet header.
- HOP_W, 8, hop-count field width.
- HOP_SHIFT, 1'b1, 1 = shift hop field right by 1 on write (CW/CCW ports); 0 = pass the packet unmodified (PE port).

Ports:
- clk  input  1  clock.
- reset  input  1  active-high synchronous reset.
- polarity  input  1  router-wide even/odd phase; toggles every cycle.
- win0  input  1  arbitrator grant for input 0.
- win1  input  1  arbitrator grant for input 1.
- in0_data  input  DATA_W  packet from input 0.
- in1_data  input  DATA_W  packet from input 1.
- wr_empty  output  1  combinational; empty flag of the write VC (feeds arbitrator `output_empty`).
- empty_even  output  1  even VC buffer empty.
- empty_odd  output  1  odd VC buffer empty.
- ri  input  1  downstream ready to accept a packet this cycle.
- so  output  1  send-out strobe; packet valid on `do_data`.
- do_data  output  DATA_W  outgoing packet.
- err  output  1  sticky protocol-error flag.

## Operation
- VC roles per cycle:
  - polarity=0: write VC = even, send VC = odd.
  - polarity=1: write VC = odd, send VC = even.
  - Write and send therefore never target the same VC in the same cycle.
- State: `full_even`, `full_odd`, `buf_even[DATA_W]`, `buf_odd[DATA_W]`, `err`.
- Write path:
  - Condition: (win0 | win1) with the write VC empty.
  - Selected data is in0_data if win0, else in1_data.
  - If HOP_SHIFT=1, hop field [HOP_LSB+HOP_W-1:HOP_LSB] is logically shifted right by 1 (MSB filled with 0). All other bits pass unchanged.
  - On the clock edge the write VC buffer loads the data and its full flag sets.
- Error cases (err sets and stays set until reset):
  - win0 & win1 in the same cycle: win0's data is written.
  - Any win while the write VC is full: the write is dropped and the buffer is unchanged.
- Send path:
  - so = full[send VC] & ri (combinational).
  - do_data = buf[send VC] when so=1, else all zeros.
  - When so=1, the send VC full flag clears on that clock edge.
  - When ri=0, the packet is held. No timeout, no drop.
- wr_empty = polarity ? !full_odd : !full_even.
- empty_even = !full_even; empty_odd = !full_odd.

## Timing
- Reset (synchronous, dominates all other activity, including mid-transfer):
  - full_even = full_odd = 0, buffers = 0, err = 0.
  - Hence so=0, do_data=0, empty_even=empty_odd=wr_empty=1 on the cycle after the reset edge.
  - A packet presented for write in the reset cycle is discarded.
- Write-to-send latency:
  - A packet written at edge k (polarity p) has its VC as the send VC in cycle k+1 (polarity !p).
  - so asserts in cycle k+1 if ri=1.
  - If ri=0, the next send opportunity is cycle k+3, the next cycle with the same polarity.
- Same-cycle write and send: a write into one VC and a send from the other complete on the same edge, independently.
- Back-to-back sends: a VC freed at edge k can be rewritten at edge k+1, when its polarity is next the write polarity.
- Throughput: one packet per VC per 2 cycles; 1 packet/cycle aggregate.
- wr_empty: combinational from registered full flags and polarity, so the arbitrator sees it in the same cycle. No dependence on win0/win1, so no combinational loop.

## Test plan
- Reset then idle, polarity toggling:
  - Expect empty_even=empty_odd=1, so=0, do_data=0, err=0 for 10 cycles.
  - Assert reset with both VCs full: both empty the next cycle, so=0.
- Single write with HOP_SHIFT=1:
  - Stimulus: polarity=0, win0=1, in0_data=64'h00F0_0000_0000_00AA.
  - Expect empty_even=0 next cycle.
  - Cycle after, polarity=1 and ri=1: so=1, do_data=64'h0078_0000_0000_00AA.
  - Then empty_even=1.
- Backpressure:
  - Stimulus: write the odd VC, then hold ri=0 for 6 cycles, then ri=1 on a polarity=0 cycle.
  - Expect so=0 throughout the hold and the packet unchanged.
  - Expect so=1 exactly once when released.
- Write to full VC:
  - Stimulus: fill even VC with 64'h1, keep ri=0, then on the next polarity=0 cycle win1=1 with 64'h2.
  - Expect err=1 (sticky) and a later send of 64'h1 only.
- Simultaneous grants:
  - Stimulus: win0=win1=1 with in0=64'h5, in1=64'h6.
  - Expect 64'h5 stored and err=1.
- Full-rate streaming, HOP_SHIFT=0:
  - Stimulus: alternating grants every cycle, ri=1, 20 distinct packets.
  - Expect 20 sends in order, each 1 cycle after its write, bits unmodified, err=0.
